zone_classifier: RTL and testbench
==================================

// Module: zone_classifier
// PURPOSE
//   Parametrised, registered index-to-zone classifier with hysteresis, successor of the fixed band LUT.
//   Maps an index onto NUM_ZONES equally spaced bands (zone 1..NUM_ZONES, 0 = outside/gap).
//   The raw zone is debounced: DATA changes only after STABLE_CNT consecutive valid samples agree.
//   Sits in the VPU pixel/feature path; FRAME_START clears the filter at each frame boundary.
// PARAMETERS
//   IDX_W      5   index width
//   ZONE_W     3   zone code width; require NUM_ZONES <= 2**ZONE_W-1
//   NUM_ZONES  4   number of bands
//   FIRST      11  first index of band 1
//   PITCH      3   index distance between band starts
//   SPAN       2   indices per band, 1 <= SPAN <= PITCH (PITCH-SPAN = gap)
//   STABLE_CNT 3   consecutive agreeing samples needed to switch, >= 1
// PORTS
//   CLK          in   1       clock, rising edge
//   RESET_N      in   1       asynchronous active-low reset
//   FRAME_START  in   1       synchronous clear of pipeline and filter
//   IN_VALID     in   1       LUT_INDEX is a sample this cycle
//   LUT_INDEX    in   IDX_W   index to classify
//   DATA         out  ZONE_W  debounced zone, registered
//   DATA_VALID   out  1       one pulse per accepted sample, aligned with DATA
//   ZONE_CHANGE  out  1       pulse: DATA took a new value this cycle
// BEHAVIOUR
//   Reset: all registers 0; DATA=0, DATA_VALID=0, ZONE_CHANGE=0, candidate=0, count=0.
//   Raw zone: off=LUT_INDEX-FIRST; if LUT_INDEX>=FIRST, off<NUM_ZONES*PITCH and off%PITCH<SPAN
//     -> off/PITCH+1, else 0. Built as per-band start/end comparators (generate loop), no divider.
//     Default geometry: 11,12->1; 14,15->2; 17,18->3; 20,21->4; all others ->0.
//   Stage 1 (cycle +1): s1_zone, s1_valid registered from IN_VALID; s1_zone holds when IN_VALID=0.
//   Stage 2 (cycle +2): filter updates only when s1_valid=1:
//     s1_zone==DATA          -> candidate<=DATA, count<=0 (deviation abandoned)
//     s1_zone==candidate     -> count+1; on reaching STABLE_CNT: DATA<=candidate, count<=0, ZONE_CHANGE=1
//     otherwise              -> candidate<=s1_zone, count<=1; if STABLE_CNT==1 switch immediately
//   DATA_VALID <= s1_valid; total latency IN_VALID -> DATA_VALID = 2 cycles, throughput 1/cycle.
//   Idle cycles (IN_VALID=0) do not break a run: consecutive means consecutive valid samples.
//   count width $clog2(STABLE_CNT+1); never exceeds STABLE_CNT-1 at rest.
//   FRAME_START=1: next edge clears s1_valid, DATA, candidate, count to 0; DATA_VALID=0, ZONE_CHANGE=0
//     (clear is not a zone change). Same-cycle IN_VALID sample is dropped; FRAME_START wins.
//   Samples in flight in stage 1 when FRAME_START asserts are discarded.
//   RESET_N low mid-run: outputs 0 immediately (async), resume classification from first valid after release.
//   ZONE_CHANGE and DATA_VALID are single-cycle; ZONE_CHANGE implies DATA_VALID.
// STRUCTURE
//   Package vpu_zone_pkg: default geometry constants (ZONE_FIRST, ZONE_PITCH, ZONE_SPAN,
//     ZONE_NUM), ZONE_NONE=0 code, zone code width.
//   Sub-module zone_hyst_filter (ZONE_W, STABLE_CNT): stage-2 candidate/count/DATA logic,
//     reusable for other debounced codes. Top holds comparators and stage 1.
//   Elaboration-time checks on SPAN<=PITCH, NUM_ZONES range, STABLE_CNT>=1.
// TESTING
//   1. STABLE_CNT=1, sweep LUT_INDEX 0..31 one per cycle -> DATA per table 2 cycles later, 0 in gaps 13,16,19 and outside.
//   2. STABLE_CNT=3, IDX=14 x3 valid -> DATA 0,0,2; ZONE_CHANGE with third DATA_VALID only.
//   3. Glitch 14,14,20,14,14,14 -> DATA stays 0 through 5th sample, becomes 2 on 6th, one ZONE_CHANGE.
//   4. From DATA=2: 17,17,15,17,17,17 -> DATA stays 2 until sixth sample then 3; the 15 resets candidate.
//   5. IN_VALID gaps of 0..4 idle cycles between 3x IDX=20 -> switch to 4 on 3rd valid; DATA_VALID only on valid.
//   6. FRAME_START with IN_VALID=1, DATA=3 -> DATA=0 next cycle, no ZONE_CHANGE, sample dropped;
//      async RESET_N pulse mid-count -> all outputs 0 before next edge.

Source files
------------

// File: rtl/vpu_zone_pkg.sv
// vpu_zone_pkg: default zone geometry shared by the VPU zone classifier
// and anything else that needs to decode its zone codes.
//   ZONE_FIRST  first index of band 1
//   ZONE_PITCH  index distance between band starts
//   ZONE_SPAN   indices per band (PITCH-SPAN indices of gap follow each band)
//   ZONE_NUM    number of bands
//   ZONE_NONE   code reported for indices outside every band
package vpu_zone_pkg;
  localparam int ZONE_IDX_W  = 5;
  localparam int ZONE_CODE_W = 3;
  localparam int ZONE_FIRST  = 11;
  localparam int ZONE_PITCH  = 3;
  localparam int ZONE_SPAN   = 2;
  localparam int ZONE_NUM    = 4;
  localparam int ZONE_NONE   = 0;
  localparam int ZONE_STABLE = 3;
endpackage

// File: rtl/zone_classifier_if.sv
// zone_classifier_if: sample stream in, debounced zone stream out.
//   master: FRAME_START, IN_VALID, LUT_INDEX -> ; <- DATA, DATA_VALID, ZONE_CHANGE
//   slave : the classifier side (directions mirrored)
interface zone_classifier_if
  import vpu_zone_pkg::*;
#(
  parameter int IDX_W  = ZONE_IDX_W,
  parameter int ZONE_W = ZONE_CODE_W
);
  logic              FRAME_START;
  logic              IN_VALID;
  logic [IDX_W-1:0]  LUT_INDEX;
  logic [ZONE_W-1:0] DATA;
  logic              DATA_VALID;
  logic              ZONE_CHANGE;

  modport master (
    output FRAME_START, IN_VALID, LUT_INDEX,
    input  DATA, DATA_VALID, ZONE_CHANGE
  );

  modport slave (
    input  FRAME_START, IN_VALID, LUT_INDEX,
    output DATA, DATA_VALID, ZONE_CHANGE
  );
endinterface

// File: rtl/zone_hyst_filter.sv
// zone_hyst_filter: hysteresis/debounce for a small code stream.
// data only moves to a new code after STABLE_CNT consecutive valid samples
// carry that code; a sample equal to the current data abandons the run.
//   clk, rst_n   clock, async active-low reset
//   clr          synchronous clear of data/candidate/count (not a change)
//   in_valid     in_code is a sample this cycle
//   in_code      code to debounce
//   data         debounced code (registered)
//   data_valid   one pulse per accepted sample
//   change       pulse when data takes a new value
module zone_hyst_filter #(
  parameter int ZONE_W     = 3,
  parameter int STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [ZONE_W-1:0] in_code,
  output logic [ZONE_W-1:0] data,
  output logic              data_valid,
  output logic              change
);
  localparam int CW = $clog2(STABLE_CNT + 1);

  logic [ZONE_W-1:0] cand;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;

  // cnt rests at <= STABLE_CNT-1, so the increment never overflows CW bits
  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      cand       <= '0;
      cnt        <= '0;
      data_valid <= 1'b0;
      change     <= 1'b0;
    end else if (clr) begin
      data       <= '0;
      cand       <= '0;
      cnt        <= '0;
      data_valid <= 1'b0;
      change     <= 1'b0;
    end else begin
      data_valid <= in_valid;
      change     <= 1'b0;
      if (in_valid) begin
        if (in_code == data) begin
          cand <= data;
          cnt  <= '0;
        end else if (in_code == cand) begin
          if (cnt_inc == CW'(STABLE_CNT)) begin
            data   <= cand;
            cnt    <= '0;
            change <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end else begin
          // new candidate; with STABLE_CNT==1 the first sample is enough
          if (STABLE_CNT == 1) begin
            data   <= in_code;
            cand   <= in_code;
            cnt    <= '0;
            change <= 1'b1;
          end else begin
            cand <= in_code;
            cnt  <= CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: rtl/zone_classifier.sv
// zone_classifier: maps LUT_INDEX onto NUM_ZONES equally spaced bands
// (1..NUM_ZONES, 0 = gap/outside), registers it (stage 1) and debounces it
// through zone_hyst_filter (stage 2). Latency IN_VALID -> DATA_VALID = 2.
//   CLK, RESET_N  clock, async active-low reset
//   bus (slave)   FRAME_START, IN_VALID, LUT_INDEX in;
//                 DATA, DATA_VALID, ZONE_CHANGE out
module zone_classifier
  import vpu_zone_pkg::*;
#(
  parameter int IDX_W      = ZONE_IDX_W,
  parameter int ZONE_W     = ZONE_CODE_W,
  parameter int NUM_ZONES  = ZONE_NUM,
  parameter int FIRST      = ZONE_FIRST,
  parameter int PITCH      = ZONE_PITCH,
  parameter int SPAN       = ZONE_SPAN,
  parameter int STABLE_CNT = ZONE_STABLE
) (
  input  logic              CLK,
  input  logic              RESET_N,
  zone_classifier_if.slave  bus
);
  if (SPAN < 1 || SPAN > PITCH) begin : g_bad_span
    $error("zone_classifier: SPAN must satisfy 1 <= SPAN <= PITCH");
  end
  if (NUM_ZONES < 1 || NUM_ZONES > (2**ZONE_W) - 1) begin : g_bad_num
    $error("zone_classifier: NUM_ZONES must be 1..2**ZONE_W-1");
  end
  if (STABLE_CNT < 1) begin : g_bad_cnt
    $error("zone_classifier: STABLE_CNT must be >= 1");
  end

  logic [NUM_ZONES-1:0] hit;
  logic [31:0]          idx32;
  logic [ZONE_W-1:0]    raw_zone;
  logic [ZONE_W-1:0]    s1_zone;
  logic                 s1_valid;

  assign idx32 = 32'(bus.LUT_INDEX);

  // one start/end comparator pair per band; bands past the index range
  // simply never hit
  for (genvar b = 0; b < NUM_ZONES; b++) begin : g_band
    localparam int BSTART = FIRST + b * PITCH;
    localparam int BEND   = BSTART + SPAN - 1;
    assign hit[b] = (idx32 >= 32'(BSTART)) && (idx32 <= 32'(BEND));
  end

  // bands are disjoint, so at most one hit bit is set
  always_comb begin
    raw_zone = ZONE_W'(ZONE_NONE);
    for (int b = 0; b < NUM_ZONES; b++)
      if (hit[b]) raw_zone = ZONE_W'(b + 1);
  end

  // stage 1: FRAME_START drops the same-cycle sample
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid <= 1'b0;
      s1_zone  <= '0;
    end else if (bus.FRAME_START) begin
      s1_valid <= 1'b0;
      s1_zone  <= '0;
    end else begin
      s1_valid <= bus.IN_VALID;
      if (bus.IN_VALID) s1_zone <= raw_zone;
    end
  end

  // stage 2: clearing on FRAME_START also discards the sample in stage 1
  zone_hyst_filter #(
    .ZONE_W     (ZONE_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_filt (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clr        (bus.FRAME_START),
    .in_valid   (s1_valid),
    .in_code    (s1_zone),
    .data       (bus.DATA),
    .data_valid (bus.DATA_VALID),
    .change     (bus.ZONE_CHANGE)
  );
endmodule

// File: tb/tb_zone_classifier.sv
module tb_zone_classifier;
  import vpu_zone_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  zone_classifier_if #(.IDX_W(5), .ZONE_W(3)) bus0 ();
  zone_classifier_if #(.IDX_W(5), .ZONE_W(3)) bus1 ();

  zone_classifier #(.IDX_W(5), .ZONE_W(3), .NUM_ZONES(4), .FIRST(11), .PITCH(3),
                    .SPAN(2), .STABLE_CNT(3))
    dut0 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus0));
  zone_classifier #(.IDX_W(5), .ZONE_W(3), .NUM_ZONES(4), .FIRST(11), .PITCH(3),
                    .SPAN(2), .STABLE_CNT(1))
    dut1 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int nstab[2] = '{3, 1};
  int m_data[2], m_dv[2], m_chg[2], m_s1v[2], m_s1z[2], hlen[2];
  int hist[2][8];

  function automatic int zone_of(int idx);
    int off;
    off = idx - ZONE_FIRST;
    if (idx >= ZONE_FIRST && off < ZONE_NUM * ZONE_PITCH && (off % ZONE_PITCH) < ZONE_SPAN)
      return off / ZONE_PITCH + 1;
    return ZONE_NONE;
  endfunction

  task automatic model_clear(int d);
    m_data[d] = 0; m_dv[d] = 0; m_chg[d] = 0; hlen[d] = 0;
  endtask

  // DATA switches when the last N valid samples since the previous switch
  // (or clear) all carry the same zone and that zone differs from DATA
  task automatic model_sample(int d, int z);
    bit all_eq;
    for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = z;
    if (hlen[d] < 8) hlen[d]++;
    all_eq = (hlen[d] >= nstab[d]);
    for (int i = 0; i < nstab[d]; i++)
      if (all_eq && hist[d][i] != z) all_eq = 1'b0;
    m_dv[d] = 1;
    m_chg[d] = 0;
    if (all_eq && z != m_data[d]) begin
      m_data[d] = z;
      m_chg[d] = 1;
      hlen[d] = 0;
    end
  endtask

  task automatic drive(bit fs, bit iv, int idx);
    bus0.FRAME_START = fs; bus0.IN_VALID = iv; bus0.LUT_INDEX = 5'(idx);
    bus1.FRAME_START = fs; bus1.IN_VALID = iv; bus1.LUT_INDEX = 5'(idx);
  endtask

  // one clock: drive, edge, advance model, sample #1 later
  task automatic step(bit fs, bit iv, int idx);
    drive(fs, iv, idx);
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (fs) model_clear(d);
      else if (m_s1v[d] != 0) model_sample(d, m_s1z[d]);
      else begin m_dv[d] = 0; m_chg[d] = 0; end
      if (fs) m_s1v[d] = 0;
      else begin
        m_s1v[d] = iv;
        if (iv) m_s1z[d] = zone_of(idx);
      end
    end
    #1;
    chk("m0.DATA", 32'(bus0.DATA), 32'(m_data[0]));
    chk("m0.DATA_VALID", 32'(bus0.DATA_VALID), 32'(m_dv[0]));
    chk("m0.ZONE_CHANGE", 32'(bus0.ZONE_CHANGE), 32'(m_chg[0]));
    chk("m1.DATA", 32'(bus1.DATA), 32'(m_data[1]));
    chk("m1.DATA_VALID", 32'(bus1.DATA_VALID), 32'(m_dv[1]));
    chk("m1.ZONE_CHANGE", 32'(bus1.ZONE_CHANGE), 32'(m_chg[1]));
  endtask

  typedef struct {
    bit fs; bit iv; int idx;
    int data; int dv; int chg;
  } vec_t;
  vec_t tbl[28];

  initial begin
    int dvcnt, chgcnt, dv_at_chg, cur;
    bit fs, iv;
    int idx;

    // expected = outputs of dut0 (STABLE_CNT=3) after that row's edge
    tbl[0]  = '{1, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 1, 14, 0, 0, 0};
    tbl[2]  = '{0, 1, 14, 0, 1, 0};
    tbl[3]  = '{0, 1, 14, 0, 1, 0};
    tbl[4]  = '{0, 0, 0,  2, 1, 1};
    tbl[5]  = '{0, 0, 0,  2, 0, 0};
    tbl[6]  = '{1, 0, 0,  0, 0, 0};
    tbl[7]  = '{0, 1, 14, 0, 0, 0};
    tbl[8]  = '{0, 1, 14, 0, 1, 0};
    tbl[9]  = '{0, 1, 20, 0, 1, 0};
    tbl[10] = '{0, 1, 14, 0, 1, 0};
    tbl[11] = '{0, 1, 14, 0, 1, 0};
    tbl[12] = '{0, 1, 14, 0, 1, 0};
    tbl[13] = '{0, 0, 0,  2, 1, 1};
    tbl[14] = '{0, 0, 0,  2, 0, 0};
    tbl[15] = '{0, 1, 17, 2, 0, 0};
    tbl[16] = '{0, 1, 17, 2, 1, 0};
    tbl[17] = '{0, 1, 15, 2, 1, 0};
    tbl[18] = '{0, 1, 17, 2, 1, 0};
    tbl[19] = '{0, 1, 17, 2, 1, 0};
    tbl[20] = '{0, 1, 17, 2, 1, 0};
    tbl[21] = '{0, 0, 0,  3, 1, 1};
    tbl[22] = '{0, 0, 0,  3, 0, 0};
    tbl[23] = '{1, 1, 17, 0, 0, 0};
    tbl[24] = '{0, 0, 0,  0, 0, 0};
    tbl[25] = '{0, 1, 20, 0, 0, 0};
    tbl[26] = '{1, 0, 0,  0, 0, 0};
    tbl[27] = '{0, 0, 0,  0, 0, 0};

    for (int d = 0; d < 2; d++) begin model_clear(d); m_s1v[d] = 0; m_s1z[d] = 0; end

    // reset state
    RESET_N = 1'b0;
    drive(0, 0, 0);
    #2;
    chk("rst.DATA0", 32'(bus0.DATA), 0);
    chk("rst.DV0", 32'(bus0.DATA_VALID), 0);
    chk("rst.CHG0", 32'(bus0.ZONE_CHANGE), 0);
    chk("rst.DATA1", 32'(bus1.DATA), 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // sweep every index through the STABLE_CNT=1 instance
    step(1, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, i);
      if (i >= 1) chk($sformatf("sweep[%0d]", i - 1), 32'(bus1.DATA), 32'(zone_of(i - 1)));
    end
    step(0, 0, 0);
    step(0, 0, 0);

    // directed table
    for (int i = 0; i < 28; i++) begin
      step(tbl[i].fs, tbl[i].iv, tbl[i].idx);
      chk($sformatf("tbl[%0d].DATA", i), 32'(bus0.DATA), 32'(tbl[i].data));
      chk($sformatf("tbl[%0d].DV", i), 32'(bus0.DATA_VALID), 32'(tbl[i].dv));
      chk($sformatf("tbl[%0d].CHG", i), 32'(bus0.ZONE_CHANGE), 32'(tbl[i].chg));
    end

    // idle gaps do not break a run
    for (int g = 0; g <= 4; g++) begin
      step(1, 0, 0);
      dvcnt = 0; chgcnt = 0; dv_at_chg = 0;
      for (int k = 0; k < 3; k++) begin
        step(0, 1, 20);
        dvcnt += int'(bus0.DATA_VALID); chgcnt += int'(bus0.ZONE_CHANGE);
        if (bus0.ZONE_CHANGE) dv_at_chg = dvcnt;
        for (int j = 0; j < g; j++) begin
          step(0, 0, 0);
          dvcnt += int'(bus0.DATA_VALID); chgcnt += int'(bus0.ZONE_CHANGE);
          if (bus0.ZONE_CHANGE) dv_at_chg = dvcnt;
        end
      end
      for (int j = 0; j < 2; j++) begin
        step(0, 0, 0);
        dvcnt += int'(bus0.DATA_VALID); chgcnt += int'(bus0.ZONE_CHANGE);
        if (bus0.ZONE_CHANGE) dv_at_chg = dvcnt;
      end
      chk($sformatf("gap%0d.DATA", g), 32'(bus0.DATA), 4);
      chk($sformatf("gap%0d.dv_count", g), 32'(dvcnt), 3);
      chk($sformatf("gap%0d.chg_count", g), 32'(chgcnt), 1);
      chk($sformatf("gap%0d.switch_on_dv", g), 32'(dv_at_chg), 3);
    end

    // async reset mid-count
    step(1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 14);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 17);
    step(0, 1, 17);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst.DATA", 32'(bus0.DATA), 0);
    chk("arst.DV", 32'(bus0.DATA_VALID), 0);
    chk("arst.CHG", 32'(bus0.ZONE_CHANGE), 0);
    chk("arst.DATA1", 32'(bus1.DATA), 0);
    for (int d = 0; d < 2; d++) begin model_clear(d); m_s1v[d] = 0; m_s1z[d] = 0; end
    drive(0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int k = 0; k < 3; k++) step(0, 1, 20);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("arst.resume", 32'(bus0.DATA), 4);

    // randomized run against the model
    cur = 14;
    for (int n = 0; n < 800; n++) begin
      fs = ($urandom_range(0, 39) == 0);
      iv = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 4) == 0) cur = $urandom_range(10, 22);
      idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : cur;
      step(fs, iv, idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
